// File: rtl/mem_pin_bridge.sv
// Bridges the GPU program/data memory ports onto the 8-bit pin interface.
// One request at a time, toggle req/ack handshake with a 2-flop ack synchroniser.
module mem_pin_bridge (
  input  logic        clk,
  input  logic        reset,
  input  logic        program_mem_read_valid,
  input  logic [7:0]  program_mem_read_address,
  output logic        program_mem_read_ready,
  output logic [15:0] program_mem_read_data,
  input  logic        data_mem_read_valid,
  input  logic [7:0]  data_mem_read_address,
  output logic        data_mem_read_ready,
  output logic [7:0]  data_mem_read_data,
  input  logic        data_mem_write_valid,
  input  logic [7:0]  data_mem_write_address,
  input  logic [7:0]  data_mem_write_data,
  output logic        data_mem_write_ready,
  output logic [7:0]  pin_ctrl,
  input  logic        pin_ack,
  input  logic [7:0]  pin_bus_in,
  output logic [7:0]  pin_bus_out,
  output logic [7:0]  pin_bus_oe
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_WDATA  = 3'd2,
    S_RDATA0 = 3'd3,
    S_RDATA1 = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [1:0] OP_IDLE   = 2'b00;
  localparam logic [1:0] OP_PROG   = 2'b01;
  localparam logic [1:0] OP_DREAD  = 2'b10;
  localparam logic [1:0] OP_DWRITE = 2'b11;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic [1:0]  op_q, op_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  prog_hi_q, prog_hi_d;
  logic [15:0] prog_data_q, prog_data_d;
  logic [7:0]  dread_data_q, dread_data_d;
  logic        prog_rdy_q, prog_rdy_d;
  logic        dread_rdy_q, dread_rdy_d;
  logic        dwrite_rdy_q, dwrite_rdy_d;
  logic [7:0]  pin_ctrl_q, pin_ctrl_d;
  logic [7:0]  bus_out_q, bus_out_d;
  logic [7:0]  bus_oe_q, bus_oe_d;
  logic        ack_meta_q, ack_sync_q;
  logic        phase_done_s;
  logic [1:0]  op_field_s;
  logic [1:0]  phase_field_s;

  // A phase completes once the synchronised ack has caught up with req.
  assign phase_done_s = (ack_sync_q == req_q);

  // Handshake sequencing, arbitration and read-data capture.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    prog_hi_d    = prog_hi_q;
    prog_data_d  = prog_data_q;
    dread_data_d = dread_data_q;
    case (state_q)
      S_IDLE: begin
        if (data_mem_write_valid) begin
          op_d    = OP_DWRITE;
          addr_d  = data_mem_write_address;
          wdata_d = data_mem_write_data;
          req_d   = ~req_q;
          state_d = S_ADDR;
        end else if (data_mem_read_valid) begin
          op_d    = OP_DREAD;
          addr_d  = data_mem_read_address;
          req_d   = ~req_q;
          state_d = S_ADDR;
        end else if (program_mem_read_valid) begin
          op_d    = OP_PROG;
          addr_d  = program_mem_read_address;
          req_d   = ~req_q;
          state_d = S_ADDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR: begin
        if (phase_done_s) begin
          req_d   = ~req_q;
          state_d = (op_q == OP_DWRITE) ? S_WDATA : S_RDATA0;
        end else begin
          state_d = S_ADDR;
        end
      end
      S_WDATA: begin
        if (phase_done_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WDATA;
        end
      end
      S_RDATA0: begin
        if (phase_done_s) begin
          if (op_q == OP_PROG) begin
            prog_hi_d = pin_bus_in;
            req_d     = ~req_q;
            state_d   = S_RDATA1;
          end else begin
            dread_data_d = pin_bus_in;
            state_d      = S_DONE;
          end
        end else begin
          state_d = S_RDATA0;
        end
      end
      S_RDATA1: begin
        if (phase_done_s) begin
          // Both bytes publish together so the instruction never shows a half-update.
          prog_data_d = {prog_hi_q, pin_bus_in};
          state_d     = S_DONE;
        end else begin
          state_d = S_RDATA1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pin and ready values for the upcoming state, registered below.
  always_comb begin
    op_field_s    = OP_IDLE;
    phase_field_s = 2'b00;
    bus_out_d     = 8'h00;
    bus_oe_d      = 8'h00;
    prog_rdy_d    = 1'b0;
    dread_rdy_d   = 1'b0;
    dwrite_rdy_d  = 1'b0;
    case (state_d)
      S_ADDR: begin
        op_field_s = op_d;
        bus_out_d  = addr_d;
        bus_oe_d   = 8'hFF;
      end
      S_WDATA: begin
        op_field_s    = op_d;
        phase_field_s = 2'b01;
        bus_out_d     = wdata_d;
        bus_oe_d      = 8'hFF;
      end
      S_RDATA0: begin
        op_field_s    = op_d;
        phase_field_s = 2'b01;
      end
      S_RDATA1: begin
        op_field_s    = op_d;
        phase_field_s = 2'b10;
      end
      S_DONE: begin
        if (state_q != S_DONE) begin
          case (op_q)
            OP_PROG:   prog_rdy_d   = 1'b1;
            OP_DREAD:  dread_rdy_d  = 1'b1;
            OP_DWRITE: dwrite_rdy_d = 1'b1;
            default:   prog_rdy_d   = 1'b0;
          endcase
        end else begin
          prog_rdy_d = 1'b0;
        end
      end
      default: begin
        op_field_s = OP_IDLE;
      end
    endcase
    pin_ctrl_d = {3'b000, phase_field_s, op_field_s, req_d};
  end

  // Ack synchroniser into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_meta_q <= 1'b0;
      ack_sync_q <= 1'b0;
    end else begin
      ack_meta_q <= pin_ack;
      ack_sync_q <= ack_meta_q;
    end
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      req_q        <= 1'b0;
      op_q         <= OP_IDLE;
      addr_q       <= 8'h00;
      wdata_q      <= 8'h00;
      prog_hi_q    <= 8'h00;
      prog_data_q  <= 16'h0000;
      dread_data_q <= 8'h00;
      prog_rdy_q   <= 1'b0;
      dread_rdy_q  <= 1'b0;
      dwrite_rdy_q <= 1'b0;
      pin_ctrl_q   <= 8'h00;
      bus_out_q    <= 8'h00;
      bus_oe_q     <= 8'h00;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      prog_hi_q    <= prog_hi_d;
      prog_data_q  <= prog_data_d;
      dread_data_q <= dread_data_d;
      prog_rdy_q   <= prog_rdy_d;
      dread_rdy_q  <= dread_rdy_d;
      dwrite_rdy_q <= dwrite_rdy_d;
      pin_ctrl_q   <= pin_ctrl_d;
      bus_out_q    <= bus_out_d;
      bus_oe_q     <= bus_oe_d;
    end
  end

  assign program_mem_read_ready = prog_rdy_q;
  assign program_mem_read_data  = prog_data_q;
  assign data_mem_read_ready    = dread_rdy_q;
  assign data_mem_read_data     = dread_data_q;
  assign data_mem_write_ready   = dwrite_rdy_q;
  assign pin_ctrl               = pin_ctrl_q;
  assign pin_bus_out            = bus_out_q;
  assign pin_bus_oe             = bus_oe_q;

endmodule

// File: tb/tb_mem_pin_bridge.sv
// Directed bench for mem_pin_bridge: a host model mirrors req with a
// programmable delay and serves read bytes; a GPU model drops valid on ready.
module tb_mem_pin_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        program_mem_read_valid = 1'b0;
  logic [7:0]  program_mem_read_address = 8'h00;
  logic        program_mem_read_ready;
  logic [15:0] program_mem_read_data;
  logic        data_mem_read_valid = 1'b0;
  logic [7:0]  data_mem_read_address = 8'h00;
  logic        data_mem_read_ready;
  logic [7:0]  data_mem_read_data;
  logic        data_mem_write_valid = 1'b0;
  logic [7:0]  data_mem_write_address = 8'h00;
  logic [7:0]  data_mem_write_data = 8'h00;
  logic        data_mem_write_ready;
  logic [7:0]  pin_ctrl;
  logic        pin_ack;
  logic [7:0]  pin_bus_in;
  logic [7:0]  pin_bus_out;
  logic [7:0]  pin_bus_oe;

  mem_pin_bridge dut (
    .clk                      (clk),
    .reset                    (reset),
    .program_mem_read_valid   (program_mem_read_valid),
    .program_mem_read_address (program_mem_read_address),
    .program_mem_read_ready   (program_mem_read_ready),
    .program_mem_read_data    (program_mem_read_data),
    .data_mem_read_valid      (data_mem_read_valid),
    .data_mem_read_address    (data_mem_read_address),
    .data_mem_read_ready      (data_mem_read_ready),
    .data_mem_read_data       (data_mem_read_data),
    .data_mem_write_valid     (data_mem_write_valid),
    .data_mem_write_address   (data_mem_write_address),
    .data_mem_write_data      (data_mem_write_data),
    .data_mem_write_ready     (data_mem_write_ready),
    .pin_ctrl                 (pin_ctrl),
    .pin_ack                  (pin_ack),
    .pin_bus_in               (pin_bus_in),
    .pin_bus_out              (pin_bus_out),
    .pin_bus_oe               (pin_bus_oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Host model: ack follows req after host_dly edges; read bytes by op/phase.
  int         host_dly = 0;
  logic [7:0] host_hi = 8'h00, host_lo = 8'h00, host_rd = 8'h00;
  logic [7:0] ack_hist;
  always @(posedge clk or posedge reset) begin
    if (reset) ack_hist <= 8'h00;
    else       ack_hist <= {ack_hist[6:0], pin_ctrl[0]};
  end
  assign pin_ack = (host_dly == 0) ? pin_ctrl[0] : ack_hist[host_dly-1];
  assign pin_bus_in = (pin_ctrl[2:1] == 2'b01 && pin_ctrl[4:3] == 2'b01) ? host_hi :
                      (pin_ctrl[2:1] == 2'b01 && pin_ctrl[4:3] == 2'b10) ? host_lo :
                      (pin_ctrl[2:1] == 2'b10 && pin_ctrl[4:3] == 2'b01) ? host_rd : 8'h00;

  int n_checks = 0;
  int n_fail = 0;

  int         got, multi, ctrl_changes, extra_rdy;
  int         order [3];
  int         lat [3];
  int         start_w, start_r, start_p;
  logic [7:0] seen_addr, seen_addr_oe, seen_wdata, seen_wdata_oe;
  logic [1:0] seen_op;

  task automatic service(input int bound, input int n_exp);
    logic [7:0] last_ctrl;
    got = 0; multi = 0; ctrl_changes = 0;
    seen_addr = 8'h00; seen_addr_oe = 8'h00; seen_wdata = 8'h00; seen_wdata_oe = 8'h00;
    seen_op = 2'b00;
    last_ctrl = pin_ctrl;
    for (int i = 0; i < bound && got < n_exp; i++) begin
      @(negedge clk);
      if (pin_ctrl !== last_ctrl) begin ctrl_changes++; last_ctrl = pin_ctrl; end
      if (pin_ctrl[2:1] != 2'b00 && pin_ctrl[4:3] == 2'b00) begin
        seen_addr = pin_bus_out; seen_addr_oe = pin_bus_oe; seen_op = pin_ctrl[2:1];
      end
      if (pin_ctrl[2:1] == 2'b11 && pin_ctrl[4:3] == 2'b01) begin
        seen_wdata = pin_bus_out; seen_wdata_oe = pin_bus_oe;
      end
      if (int'(data_mem_write_ready) + int'(data_mem_read_ready) + int'(program_mem_read_ready) > 1) multi++;
      if (data_mem_write_ready && got < 3) begin
        data_mem_write_valid = 1'b0; order[got] = 3; lat[got] = cyc - start_w; got++;
      end
      if (data_mem_read_ready && got < 3) begin
        data_mem_read_valid = 1'b0; order[got] = 2; lat[got] = cyc - start_r; got++;
      end
      if (program_mem_read_ready && got < 3) begin
        program_mem_read_valid = 1'b0; order[got] = 1; lat[got] = cyc - start_p; got++;
      end
    end
  endtask

  task automatic settle();
    extra_rdy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (data_mem_write_ready || data_mem_read_ready || program_mem_read_ready) extra_rdy++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (pin_ctrl !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 00", pin_ctrl); end
    n_checks++; if (pin_bus_out !== 8'h00) begin n_fail++; $display("FAIL reset_bus_out: got %h expected 00", pin_bus_out); end
    n_checks++; if (pin_bus_oe !== 8'h00) begin n_fail++; $display("FAIL reset_oe: got %h expected 00", pin_bus_oe); end
    n_checks++; if ({program_mem_read_ready, data_mem_read_ready, data_mem_write_ready} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 000", {program_mem_read_ready, data_mem_read_ready, data_mem_write_ready}); end
    n_checks++; if (program_mem_read_data !== 16'h0000) begin n_fail++; $display("FAIL reset_prog_data: got %h expected 0000", program_mem_read_data); end
    n_checks++; if (data_mem_read_data !== 8'h00) begin n_fail++; $display("FAIL reset_read_data: got %h expected 00", data_mem_read_data); end
    reset = 1'b0;
    @(negedge clk);
    data_mem_write_valid = 1'b1; data_mem_write_address = 8'h33; data_mem_write_data = 8'h77;
    @(negedge clk);
    n_checks++; if (pin_ctrl[4:1] !== 4'b0011 || pin_bus_oe !== 8'hFF) begin
      n_fail++; $display("FAIL reset_pre_addr: got ctrl %h oe %h expected op 11 phase 00 oe ff", pin_ctrl, pin_bus_oe); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (pin_ctrl !== 8'h00 || pin_bus_oe !== 8'h00 || pin_bus_out !== 8'h00) begin
      n_fail++; $display("FAIL reset_async: got ctrl %h oe %h out %h expected 00 00 00", pin_ctrl, pin_bus_oe, pin_bus_out); end
    data_mem_write_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    settle();
    n_checks++; if (extra_rdy !== 0) begin n_fail++; $display("FAIL reset_no_ready: got %0d pulses expected 0", extra_rdy); end
  endtask

  task automatic test_write();
    host_dly = 0;
    @(negedge clk);
    data_mem_write_valid = 1'b1; data_mem_write_address = 8'h40; data_mem_write_data = 8'h5A;
    start_w = cyc + 1;
    service(40, 1);
    n_checks++; if (got !== 1 || order[0] !== 3) begin n_fail++; $display("FAIL write_done: got %0d/%0d expected 1/3", got, order[0]); end
    n_checks++; if (lat[0] !== 6) begin n_fail++; $display("FAIL write_latency: got %0d expected 6", lat[0]); end
    n_checks++; if (seen_addr !== 8'h40 || seen_addr_oe !== 8'hFF || seen_op !== 2'b11) begin
      n_fail++; $display("FAIL write_addr: got %h oe %h op %b expected 40 ff 11", seen_addr, seen_addr_oe, seen_op); end
    n_checks++; if (seen_wdata !== 8'h5A || seen_wdata_oe !== 8'hFF) begin
      n_fail++; $display("FAIL write_data: got %h oe %h expected 5a ff", seen_wdata, seen_wdata_oe); end
    settle();
    n_checks++; if (extra_rdy !== 0) begin n_fail++; $display("FAIL write_single: got %0d extra expected 0", extra_rdy); end
  endtask

  task automatic test_slow_read();
    host_dly = 5; host_rd = 8'h3C;
    @(negedge clk);
    data_mem_read_valid = 1'b1; data_mem_read_address = 8'h07;
    start_r = cyc + 1;
    service(60, 1);
    n_checks++; if (got !== 1 || order[0] !== 2) begin n_fail++; $display("FAIL slow_done: got %0d/%0d expected 1/2", got, order[0]); end
    n_checks++; if (lat[0] !== 16) begin n_fail++; $display("FAIL slow_latency: got %0d expected 16", lat[0]); end
    n_checks++; if (data_mem_read_data !== 8'h3C) begin n_fail++; $display("FAIL slow_data: got %h expected 3c", data_mem_read_data); end
    n_checks++; if (ctrl_changes !== 3) begin n_fail++; $display("FAIL slow_ctrl_stable: got %0d changes expected 3", ctrl_changes); end
    n_checks++; if (seen_addr !== 8'h07 || seen_op !== 2'b10) begin
      n_fail++; $display("FAIL slow_addr: got %h op %b expected 07 10", seen_addr, seen_op); end
    n_checks++; if (program_mem_read_data !== 16'h0000) begin n_fail++; $display("FAIL slow_prog_untouched: got %h expected 0000", program_mem_read_data); end
    settle();
    host_dly = 0;
  endtask

  task automatic test_prog_read();
    host_dly = 0; host_hi = 8'hAB; host_lo = 8'hCD;
    settle();
    @(negedge clk);
    program_mem_read_valid = 1'b1; program_mem_read_address = 8'h12;
    start_p = cyc + 1;
    service(40, 1);
    n_checks++; if (got !== 1 || order[0] !== 1) begin n_fail++; $display("FAIL prog_done: got %0d/%0d expected 1/1", got, order[0]); end
    n_checks++; if (lat[0] !== 9) begin n_fail++; $display("FAIL prog_latency: got %0d expected 9", lat[0]); end
    n_checks++; if (program_mem_read_data !== 16'hABCD) begin n_fail++; $display("FAIL prog_data: got %h expected abcd", program_mem_read_data); end
    n_checks++; if (seen_addr !== 8'h12 || seen_op !== 2'b01) begin
      n_fail++; $display("FAIL prog_addr: got %h op %b expected 12 01", seen_addr, seen_op); end
    n_checks++; if (data_mem_read_data !== 8'h3C) begin n_fail++; $display("FAIL prog_dread_untouched: got %h expected 3c", data_mem_read_data); end
    settle();
    n_checks++; if (extra_rdy !== 0) begin n_fail++; $display("FAIL prog_single: got %0d extra expected 0", extra_rdy); end
  endtask

  task automatic test_arbitration();
    host_dly = 0; host_rd = 8'h99; host_hi = 8'h11; host_lo = 8'h22;
    @(negedge clk);
    data_mem_write_valid = 1'b1; data_mem_write_address = 8'h50; data_mem_write_data = 8'hA5;
    data_mem_read_valid = 1'b1; data_mem_read_address = 8'h51;
    program_mem_read_valid = 1'b1; program_mem_read_address = 8'h52;
    start_w = cyc + 1; start_r = cyc + 1; start_p = cyc + 1;
    service(100, 3);
    n_checks++; if (got !== 3) begin n_fail++; $display("FAIL arb_count: got %0d expected 3", got); end
    n_checks++; if (order[0] !== 3 || order[1] !== 2 || order[2] !== 1) begin
      n_fail++; $display("FAIL arb_order: got %0d %0d %0d expected 3 2 1", order[0], order[1], order[2]); end
    n_checks++; if (lat[0] !== 6) begin n_fail++; $display("FAIL arb_write_latency: got %0d expected 6", lat[0]); end
    n_checks++; if (multi !== 0) begin n_fail++; $display("FAIL arb_one_ready: got %0d overlaps expected 0", multi); end
    n_checks++; if (data_mem_read_data !== 8'h99 || program_mem_read_data !== 16'h1122) begin
      n_fail++; $display("FAIL arb_data: got %h %h expected 99 1122", data_mem_read_data, program_mem_read_data); end
    settle();
    n_checks++; if (extra_rdy !== 0) begin n_fail++; $display("FAIL arb_single: got %0d extra expected 0", extra_rdy); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_slow_read();
    test_prog_read();
    test_arbitration();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_pin_bridge.md
# mem_pin_bridge

Serialises the GPU core's three memory ports (program read, data read, data write) onto the chip's 8-bit pin interface so an external host MCU can serve as program and data memory. It sits between the `gpu` instance and the top-level pin wrapper. It arbitrates one request at a time, runs a toggle req/ack handshake with the host through a 2-flop synchroniser, and returns a one-cycle ready pulse to the GPU.

## Interface
No parameters. Widths are fixed to the GPU: 8-bit addresses, 16-bit instructions, 8-bit data.
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high
- program_mem_read_valid  in  1  fetch request, held until ready
- program_mem_read_address  in  8  instruction address
- program_mem_read_ready  out  1  one-cycle completion pulse
- program_mem_read_data  out  16  instruction; held until next program read completes
- data_mem_read_valid  in  1  data read request, held until ready
- data_mem_read_address  in  8  data address
- data_mem_read_ready  out  1  one-cycle completion pulse
- data_mem_read_data  out  8  read byte; held until next data read completes
- data_mem_write_valid  in  1  write request, held until ready
- data_mem_write_address  in  8  data address
- data_mem_write_data  in  8  write byte
- data_mem_write_ready  out  1  one-cycle completion pulse
- pin_ctrl  out  8  to uo_out: [0] req toggle, [2:1] op (00 idle, 01 prog read, 10 data read, 11 data write), [4:3] phase (00 addr, 01 byte0, 10 byte1), [7:5] 0
- pin_ack  in  1  from ui_in[0]: host ack toggle, asynchronous to clk
- pin_bus_in  in  8  from uio_in: read data from host
- pin_bus_out  out  8  to uio_out: address / write data
- pin_bus_oe  out  8  to uio_oe: 8'hFF when driving, 8'h00 otherwise

## Operation
- States: IDLE, ADDR, WDATA, RDATA0, RDATA1, DONE.
- IDLE, arbitration by fixed priority: data write > data read > program read. The winner's op and address (plus write data) are latched. The FSM goes to ADDR and toggles req. With no valid, it stays in IDLE.
- ADDR: pin_bus_out = address, oe = FF, phase 00.
- Phase completion: a phase ends on the edge where the synchronised ack first equals req. On that edge the FSM advances and toggles req again, except when entering DONE.
- Phase sequences after ADDR:
  - write: WDATA (bus_out = data, oe = FF, phase 01), then DONE.
  - data read: RDATA0 (oe = 00, phase 01), then DONE.
  - program read: RDATA0 (high byte, [15:8]), then RDATA1 (low byte, [7:0], phase 10), then DONE.
- Read capture: pin_bus_in is captured into the output register on the completing edge of each RDATA phase. The host holds read data stable from before its ack toggle until the next req toggle.
- DONE: pulses the ready matching the latched op for exactly one cycle; op drives 00, oe = 00; returns to IDLE. The next IDLE cycle re-arbitrates. The GPU drops valid the cycle after ready, so no request is served twice.
- Only one ready is ever high in a cycle. Read data outputs change only on their own capture edges.
- Starvation of program reads under continuous data traffic is accepted; data requests are bounded by the warp's LSUs.

## Timing
- Asynchronous reset values:
  - state IDLE; req, both synchroniser flops and all readies 0
  - pin_ctrl 8'h00, pin_bus_out 8'h00, pin_bus_oe 8'h00
  - program_mem_read_data 16'h0000, data_mem_read_data 8'h00
- The host must hold pin_ack = 0 through reset.
- Reset mid-transaction aborts it: no ready pulse, and the bus is released (oe 00) immediately.
- Synchronised ack lags pin_ack by 2 edges. With a host that mirrors req combinationally, each phase takes 3 edges.
- Ready latency is 3·P edges after the edge that sampled valid, with P = 2 for data read/write and P = 3 for program read. Each extra cycle of host delay adds 1 per phase.
- Bus turnaround: oe changes on the same edge as the req toggle. The host drives uio only while op = prog/data read and phase ≠ 00.
- A valid that rises while a transaction is in progress waits; it is arbitrated in the first IDLE cycle after DONE.

## Test plan
- Reset: assert reset mid-ADDR of a write -> all outputs at reset values asynchronously; no data_mem_write_ready ever pulses.
- Program read: addr 8'h12, host returns 8'hAB then 8'hCD with immediate ack -> pin_bus_out = 8'h12 in ADDR; program_mem_read_data = 16'hABCD; ready pulses once, 9 edges after valid sampled.
- Data write: addr 8'h40, data 8'h5A -> ADDR shows 8'h40, WDATA shows 8'h5A with oe = FF, op 11; data_mem_write_ready pulses once after 6 edges.
- Arbitration: all three valids high at once -> order of service is write, data read, program read; exactly one ready per transaction, never two in one cycle.
- Slow host: ack delayed 5 cycles per phase on a data read of addr 8'h07 returning 8'h3C -> req/phase held stable while waiting; data_mem_read_data = 8'h3C; latency 6 + 2·5 = 16 edges.
